// File: rtl/qupls4_decode_rd_group.sv
// Qupls4 destination-register group decoder: per-lane Rd, write/zero/range/youngest flags,
// writer count, registered behind a 2-entry skid buffer.

package Qupls4_pkg;

    typedef logic [6:0] aregno_t;

    typedef enum logic [6:0] {
        OP_NOP,
        OP_BRANCH,
        OP_STORE,
        OP_FLTH,
        OP_FLTS,
        OP_FLTD,
        OP_FLTQ,
        OP_CSR,
        OP_ADDI,
        OP_SUBFI,
        OP_CMPI,
        OP_CMPUI,
        OP_ANDI,
        OP_ORI,
        OP_XORI,
        OP_MULI,
        OP_MULUI,
        OP_DIVI,
        OP_DIVUI,
        OP_SHIFT,
        OP_BSR,
        OP_JSR,
        OP_LDB,
        OP_LDBZ,
        OP_LDW,
        OP_LDWZ,
        OP_LDT,
        OP_LDTZ,
        OP_LOAD,
        OP_LOADA,
        OP_LDV,
        OP_AMO,
        OP_CMPSWAP
    } opcode_t;

    typedef struct packed {
        opcode_t opcode;
        aregno_t Rd;
    } micro_op_t;

endpackage

module qupls4_decode_rd_group
    import Qupls4_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned AREG_BITS = 7,
    parameter int unsigned NAREGS    = 128
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES-1:0]                     in_lane_v,
    input  micro_op_t [LANES-1:0]                in_uop,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES-1:0][AREG_BITS-1:0]      out_rd,
    output logic [LANES-1:0]                     out_rdz,
    output logic [LANES-1:0]                     out_wr,
    output logic [LANES-1:0]                     out_last,
    output logic [$clog2(LANES+1)-1:0]           out_nwr,
    output logic [LANES-1:0]                     out_exc
);

    localparam int unsigned NWR_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [LANES-1:0][AREG_BITS-1:0] rd;
        logic [LANES-1:0]                rdz;
        logic [LANES-1:0]                wr;
        logic [LANES-1:0]                last;
        logic [LANES-1:0]                exc;
        logic [NWR_W-1:0]                nwr;
    } grp_t;

    localparam grp_t GRP_RST = '{rd: '0, rdz: '1, wr: '0, last: '0, exc: '0, nwr: '0};

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    function automatic logic is_writer(input opcode_t op);
        case (op)
            OP_FLTH, OP_FLTS, OP_FLTD, OP_FLTQ, OP_CSR,
            OP_ADDI, OP_SUBFI, OP_CMPI, OP_CMPUI, OP_ANDI, OP_ORI, OP_XORI,
            OP_MULI, OP_MULUI, OP_DIVI, OP_DIVUI, OP_SHIFT, OP_BSR, OP_JSR,
            OP_LDB, OP_LDBZ, OP_LDW, OP_LDWZ, OP_LDT, OP_LDTZ,
            OP_LOAD, OP_LOADA, OP_LDV, OP_AMO, OP_CMPSWAP: is_writer = 1'b1;
            default:                                       is_writer = 1'b0;
        endcase
    endfunction

    logic [LANES-1:0] w_hit;
    grp_t             w_dec;

    always_comb begin
        w_hit = '0;
        w_dec = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_hit[i]     = in_lane_v[i] & is_writer(in_uop[i].opcode);
            w_dec.rd[i]  = w_hit[i] ? AREG_BITS'(in_uop[i].Rd) : '0;
            w_dec.rdz[i] = ~|w_dec.rd[i];
            // Widened compare folds to 0 when NAREGS covers the whole register space.
            w_dec.exc[i] = w_hit[i] & (32'(w_dec.rd[i]) >= NAREGS);
            w_dec.wr[i]  = w_hit[i] & ~w_dec.rdz[i] & ~w_dec.exc[i];
        end
        for (int unsigned i = 0; i < LANES; i++) begin
            w_dec.last[i] = w_dec.wr[i];
            for (int unsigned j = i + 1; j < LANES; j++) begin
                if (w_dec.wr[j] && (w_dec.rd[j] == w_dec.rd[i])) begin
                    w_dec.last[i] = 1'b0;
                end
            end
            w_dec.nwr = w_dec.nwr + NWR_W'(w_dec.wr[i]);
        end
    end

    state_t r_state;
    state_t w_state_nxt;
    grp_t   r_head;
    grp_t   r_skid;
    logic   w_push;
    logic   w_pop;
    logic   w_ld_head_in;
    logic   w_ld_head_skid;
    logic   w_ld_skid;

    assign in_ready  = (r_state != ST_TWO);
    assign out_valid = (r_state != ST_EMPTY);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ld_head_in   = 1'b0;
        w_ld_head_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_ld_head_in = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = ST_TWO;
                        w_ld_skid   = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_head_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= GRP_RST;
            r_skid <= GRP_RST;
        end else begin
            if (w_ld_head_in) begin
                r_head <= w_dec;
            end else if (w_ld_head_skid) begin
                r_head <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign out_rd   = r_head.rd;
    assign out_rdz  = r_head.rdz;
    assign out_wr   = r_head.wr;
    assign out_last = r_head.last;
    assign out_exc  = r_head.exc;
    assign out_nwr  = r_head.nwr;

endmodule
